// File: rtl/tdc_acc_pkg.sv
// tdc_acc_pkg: default widths plus saturating-add and mean/sum selection helpers shared by the accumulator
package tdc_acc_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF = 10;
  localparam int ACC_W_DEF = 20;
  localparam int SHIFT_W = 5;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] sum, input logic [MAX_W-1:0] sample, input int acc_w);
    logic [MAX_W-1:0] s, lim;
    s = sum + sample;
    lim = (MAX_W'(1) << acc_w) - MAX_W'(1);
    // {ovf, value} packed in the low acc_w+1 bits so callers can take it with one size cast
    return s > lim ? (lim | (MAX_W'(1) << acc_w)) : s;
  endfunction
  function automatic logic [MAX_W-1:0] apply_mode(input logic [MAX_W-1:0] sum, input logic [SHIFT_W-1:0] shift, input logic mean);
    return mean ? sum >> shift : sum;
  endfunction
endpackage

// File: rtl/tdc_acc_channel.sv
// tdc_acc_channel: one channel's frame counter, saturating sum and latched config; en=accepted sample, done=frame completes this cycle with res_* final values
module tdc_acc_channel
  import tdc_acc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [DATA_W-1:0]  data,
  input  logic [CNT_W-1:0]   cfg_len,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_mean,
  output logic               done,
  output logic [ACC_W-1:0]   res_sum,
  output logic               res_ovf,
  output logic [SHIFT_W-1:0] res_shift,
  output logic               res_mean
);
  logic [CNT_W-1:0] cnt, len, l;
  logic [ACC_W-1:0] sum, sum_a;
  logic [SHIFT_W-1:0] shift;
  logic ovf, mean, first, last, ovf_a;
  // the first sample of a frame uses live cfg_* so an N=1 frame completes without waiting for the latch
  always_comb begin
    first = cnt == '0;
    l = first ? (cfg_len == '0 ? CNT_W'(1) : cfg_len) : len;
    {ovf_a, sum_a} = (ACC_W+1)'(sat_add(MAX_W'(sum), MAX_W'(data), ACC_W));
    last = cnt + CNT_W'(1) == l;
    done = en && last;
    res_sum = sum_a;
    res_ovf = ovf || ovf_a;
    res_shift = first ? cfg_shift : shift;
    res_mean = first ? cfg_mean : mean;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      sum <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
      sum <= last ? '0 : sum_a;
      ovf <= !last && res_ovf;
    end
  end
  always_ff @(posedge clk) begin
    if (en && first) begin
      len <= l;
      shift <= cfg_shift;
      mean <= cfg_mean;
    end
  end
endmodule

// File: rtl/tdc_accumulator.sv
// tdc_accumulator: NUM_CH-channel frame accumulator; in_* samples with cfg_* frame setup, out_* one-cycle tagged sum/mean result with saturation flag
module tdc_accumulator
  import tdc_acc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int NUM_CH = 4,
  parameter int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [CH_W-1:0]    in_ch,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CNT_W-1:0]   cfg_len,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_mean,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_ch,
  output logic [ACC_W-1:0]   out_data,
  output logic               out_ovf
);
  logic accept, sel_ovf, sel_mean;
  logic [NUM_CH-1:0] en, done, res_ovf, res_mean;
  logic [ACC_W-1:0] res_sum [NUM_CH];
  logic [SHIFT_W-1:0] res_shift [NUM_CH];
  logic [CH_W-1:0] sel_ch;
  logic [ACC_W-1:0] sel_sum;
  logic [SHIFT_W-1:0] sel_shift;
  assign accept = in_valid && !clr && {1'b0, in_ch} < (CH_W+1)'(NUM_CH);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign en[i] = accept && in_ch == CH_W'(i);
    tdc_acc_channel #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_ch (
      .clk(clk), .rst(rst), .clr(clr), .en(en[i]), .data(in_data),
      .cfg_len(cfg_len), .cfg_shift(cfg_shift), .cfg_mean(cfg_mean),
      .done(done[i]), .res_sum(res_sum[i]), .res_ovf(res_ovf[i]),
      .res_shift(res_shift[i]), .res_mean(res_mean[i])
    );
  end
  // only the channel that took this cycle's sample can complete, so done is one-hot or zero
  always_comb begin
    sel_ch = '0;
    sel_sum = '0;
    sel_ovf = 1'b0;
    sel_shift = '0;
    sel_mean = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (done[i]) begin
        sel_ch = CH_W'(i);
        sel_sum = res_sum[i];
        sel_ovf = res_ovf[i];
        sel_shift = res_shift[i];
        sel_mean = res_mean[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch <= '0;
      out_data <= '0;
      out_ovf <= 1'b0;
    end else begin
      out_valid <= |done;
      if (|done) begin
        out_ch <= sel_ch;
        out_data <= ACC_W'(apply_mode(MAX_W'(sel_sum), sel_shift, sel_mean));
        out_ovf <= sel_ovf;
      end
    end
  end
endmodule

// File: tb/tb_tdc_accumulator.sv
// tb_tdc_accumulator: directed plus random stimulus against a frame-level reference model of tdc_accumulator
module tb_tdc_accumulator;
  localparam int NUM_CH = 3;
  localparam longint MAXV = (64'd1 << 20) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0, clr = 1'b0, in_valid = 1'b0, cfg_mean = 1'b0;
  logic [1:0] in_ch = '0;
  logic [15:0] in_data = '0;
  logic [9:0] cfg_len = '0;
  logic [4:0] cfg_shift = '0;
  logic out_valid, out_ovf;
  logic [1:0] out_ch;
  logic [19:0] out_data;
  int checks = 0, passed = 0;
  int m_cnt [NUM_CH], m_len [NUM_CH], m_shift [NUM_CH];
  bit m_mean [NUM_CH];
  longint m_sum [NUM_CH];
  bit e_valid = 0, e_ovf = 0;
  int e_ch = 0;
  longint e_data = 0;
  tdc_accumulator #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .cfg_len(cfg_len), .cfg_shift(cfg_shift), .cfg_mean(cfg_mean),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_ovf(out_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s got %0d exp %0d", tag, got, exp);
  endtask
  // frame model: unbounded sum per channel, clamped and flagged only when the frame closes
  task automatic model();
    int c;
    longint res;
    e_valid = 0;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin m_cnt[i] = 0; m_sum[i] = 0; end
      e_ch = 0; e_data = 0; e_ovf = 0;
    end else if (clr) begin
      for (int i = 0; i < NUM_CH; i++) begin m_cnt[i] = 0; m_sum[i] = 0; end
    end else if (in_valid && int'(in_ch) < NUM_CH) begin
      c = int'(in_ch);
      if (m_cnt[c] == 0) begin
        m_len[c] = cfg_len == 0 ? 1 : int'(cfg_len);
        m_shift[c] = int'(cfg_shift);
        m_mean[c] = cfg_mean;
      end
      m_sum[c] += longint'(in_data);
      m_cnt[c]++;
      if (m_cnt[c] == m_len[c]) begin
        res = m_sum[c] > MAXV ? MAXV : m_sum[c];
        e_valid = 1;
        e_ch = c;
        e_ovf = m_sum[c] > MAXV;
        e_data = m_mean[c] ? res >> m_shift[c] : res;
        m_cnt[c] = 0;
        m_sum[c] = 0;
      end
    end
  endtask
  task automatic step(input bit v, input int ch, input int d);
    in_valid = v;
    in_ch = 2'(ch);
    in_data = 16'(d);
    @(posedge clk);
    #1;
    model();
    chk("out_valid", out_valid, e_valid);
    chk("out_ch", out_ch, e_ch);
    chk("out_data", out_data, e_data);
    chk("out_ovf", out_ovf, e_ovf);
  endtask
  initial begin
    rst = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_data", out_data, 0);
    rst = 0;
    cfg_len = 10;
    for (int i = 1; i <= 10; i++) step(1, 0, i);
    chk("n10_valid", out_valid, 1);
    chk("n10_sum", out_data, 55);
    step(0, 0, 0);
    chk("n10_one_cycle", out_valid, 0);
    cfg_len = 4;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 100);
      if (i == 3) chk("il_ch0", out_data, 400);
      step(1, 1, 7);
      if (i == 3) chk("il_ch1", out_data, 28);
    end
    cfg_len = 8; cfg_mean = 1; cfg_shift = 3;
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) cfg_len = 2;
      step(1, 2, 8 * i);
    end
    chk("mean36", out_data, 36);
    step(1, 2, 5);
    chk("len2_pending", out_valid, 0);
    step(1, 2, 7);
    chk("len2_done", out_valid, 1);
    cfg_mean = 0; cfg_len = 32;
    for (int i = 0; i < 32; i++) step(1, 1, 16'hFFFF);
    chk("sat_data", out_data, 20'hFFFFF);
    chk("sat_ovf", out_ovf, 1);
    for (int i = 0; i < 32; i++) step(1, 1, 0);
    chk("zero_ovf", out_ovf, 0);
    cfg_len = 5;
    for (int i = 0; i < 3; i++) step(1, 2, 1000);
    clr = 1;
    step(1, 2, 999);
    chk("clr_no_strobe", out_valid, 0);
    clr = 0;
    for (int i = 0; i < 5; i++) step(1, 2, 10);
    chk("flush_sum", out_data, 50);
    cfg_len = 3;
    step(1, 0, 1);
    step(1, 3, 500);
    step(1, 0, 2);
    step(1, 3, 500);
    step(1, 0, 3);
    chk("ignore_sum", out_data, 6);
    cfg_len = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 20 + i);
      chk("len0_strobe", out_valid, 1);
    end
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 199) == 0;
      clr = $urandom_range(0, 59) == 0;
      cfg_len = $urandom_range(0, 9) == 0 ? 10'd20 : 10'($urandom_range(0, 6));
      cfg_shift = 5'($urandom_range(0, 24));
      cfg_mean = 1'($urandom_range(0, 1));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3),
           $urandom_range(0, 2) == 0 ? 16'hFFFF : $urandom_range(0, 65535));
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/tdc_accumulator.md
# tdc_accumulator

Parametrised, multi-channel successor to the single-channel TDC sample accumulator. It sums a programmable number of 16-bit (default) samples per channel and emits one tagged result per completed frame, either as a raw sum or shifted by a programmable amount to give a mean. It sits between the TDC measurement pipeline and the readout/logging logic on the DE0 board. Compared with the previous block, it loses no samples at frame boundaries, saturates on overflow, and produces an explicit output strobe.

## Interface
- `DATA_W`, 16: input sample width (unsigned).
- `CNT_W`, 10: frame-length counter width; maximum frame length is 2^CNT_W − 1.
- `ACC_W`, 20: accumulator and result width (unsigned, saturating).
- `NUM_CH`, 4: number of independent channels; must be ≥ 1.
- `CH_W`, $clog2(NUM_CH) with a minimum of 1: channel tag width.

- `clk`: in, 1 bit. Single clock; all logic on the rising edge.
- `rst`: in, 1 bit. Synchronous, active-high reset.
- `clr`: in, 1 bit. Synchronous flush of all channel frames; output registers are untouched.
- `in_valid`: in, 1 bit. Sample strobe; one sample per cycle at most.
- `in_ch`: in, CH_W bits. Channel of the sample.
- `in_data`: in, DATA_W bits. Sample value.
- `cfg_len`: in, CNT_W bits. Frame length N; a value of 0 is treated as 1.
- `cfg_shift`: in, 5 bits. Right shift applied to the sum in mean mode.
- `cfg_mean`: in, 1 bit. 0 selects the raw sum; 1 selects sum >> shift.
- `out_valid`: out, 1 bit. One-cycle result strobe.
- `out_ch`: out, CH_W bits. Channel of the result.
- `out_data`: out, ACC_W bits. Result value.
- `out_ovf`: out, 1 bit. Set when the frame saturated.

## Operation
- **Per-channel state:**
  - `cnt` (CNT_W bits), `sum` (ACC_W bits), `ovf` (sticky).
  - Latched config: `len`, `shift`, `mean`.
- **Config latching:** on an accepted sample with `cnt == 0`, `cfg_*` are latched for that channel. Changes to `cfg_*` mid-frame take effect from the next frame only.
- **Accept:** `in_valid && !clr && in_ch < NUM_CH`. A sample with `in_ch ≥ NUM_CH` is dropped silently, with no state change.
- **Accumulate:**
  - new_sum = sum + zero-extended `in_data`.
  - If new_sum exceeds 2^ACC_W − 1: store all-ones and set `ovf`.
  - Once saturated, the sum stays at all-ones for the rest of the frame.
- **Completion:** when an accepted sample makes `cnt + 1 == len`, that sample is included in the result. The channel then resets `cnt`, `sum` and `ovf` to 0 in the same cycle.
- **Result:**
  - `mean = 0`: `out_data` = final sum.
  - `mean = 1`: `out_data` = final sum >> `shift`, logical shift; a shift ≥ ACC_W gives 0.
  - `out_ovf` = final `ovf`.
  - A saturated mean is all-ones >> `shift`; `out_ovf` flags it.
- **Channel independence:** frames are fully independent per channel. Interleaved samples never mix between channels.
- **Reset (`rst`):** all channels go to `cnt = sum = ovf = 0`. `out_valid`, `out_ch`, `out_data` and `out_ovf` all reset to 0.
- **Flush (`clr`):**
  - Same per-channel clear as `rst`.
  - `out_*` hold their values; `out_valid` is 0 on the next cycle.
  - `clr` together with `in_valid`: `clr` wins and the sample is lost.
- **Precedence:** `rst` > `clr` > sample.

## Timing
- **Latency:** the completing sample at edge t produces `out_valid = 1` for exactly one cycle after edge t, with `out_ch`, `out_data` and `out_ovf` valid in that cycle.
- **Hold:** `out_ch`, `out_data` and `out_ovf` hold their values until the next strobe.
- **Throughput:** one sample per cycle, sustained, with any channel sequence and no stall. At most one completion per cycle, because there is at most one sample per cycle.
- **N = 1:** every accepted sample produces a result one cycle later.
- **Back-to-back frames:** a completion in one cycle followed by a sample on the same channel in the next cycle starts the new frame with no lost sample.
- **Reset mid-frame:** partial sums are discarded and no strobe is generated.

## Structure
- **Package `tdc_acc_pkg`:**
  - Default `DATA_W`, `CNT_W` and `ACC_W` constants.
  - Shift-field width constant (5).
  - Function `sat_add(sum, sample)` returning {ovf, value}.
  - Function `apply_mode(sum, shift, mean)`.
- **Sub-module `tdc_acc_channel`:** holds one channel's `cnt`/`sum`/`ovf`/config registers and produces `done` plus the final {sum, ovf, shift, mean}.
  - The top instantiates `NUM_CH` copies with a generate loop.
  - The top decodes `in_ch` to per-channel enables.
  - The top selects the single `done` channel into the output register.

## Test plan
- **Reset:** assert `rst` for 2 cycles → all outputs 0. Then N = 10, mean = 0, samples 1..10 on ch 0 → one strobe, `out_ch = 0`, `out_data = 55`, `out_ovf = 0`, one cycle after the 10th sample.
- **Interleave:** ch 0 and ch 1 alternate with N = 4. Ch 0 samples = 100 each, ch 1 samples = 7 each → strobes give ch 0 → 400 and ch 1 → 28, in completion order, with no cross-talk.
- **Mean and config latching:** N = 8, mean = 1, shift = 3, samples 8, 16, …, 64 → `out_data = 36`. Change `cfg_len` to 2 mid-frame → that frame still completes at 8 samples, and the next frame completes at 2.
- **Saturation (default ACC_W = 20):** N = 32, samples 0xFFFF → `out_data = 0xFFFFF`, `out_ovf = 1`. The next frame of zeros gives `out_data = 0`, `out_ovf = 0`.
- **Flush and edge cases:**
  - 3 samples into an N = 5 frame, pulse `clr` while `in_valid` is high → no strobe, and the next 5 samples sum from zero.
  - `in_ch = NUM_CH` → ignored.
  - `cfg_len = 0` → every accepted sample produces a strobe.
